// File: rtl/fan_tach_meter_pkg.sv
// Shared clock-rate and width constants for the fan controller path.
`default_nettype none

package fan_tach_meter_pkg;

   localparam int unsigned CLK_HZ           = 10_000_000;
   localparam int unsigned ADC_BITWIDTH_DEF = 8;
   localparam int unsigned FILTER_LEN_DEF   = 4;

   // PWM/PID dividers used by the controller top level.
   localparam int unsigned PWM_CLK_DIV = 399;
   localparam int unsigned PID_CLK_DIV = 99_999;

   function automatic logic [23:0] gate_div_for_ms(input int unsigned ms);
      return 24'(CLK_HZ / 1000 * ms - 1);
   endfunction

   localparam logic [23:0] GATE_CLK_DIV_DEF = gate_div_for_ms(1000);

endpackage

`default_nettype wire

// File: rtl/tach_glitch_filter.sv
// Tach line synchroniser and run-length deglitcher with a falling-edge strobe.
`default_nettype none

module tach_glitch_filter #(
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic tach_i,
   output logic fall_o
);

   localparam int unsigned RUN_W = $clog2(FILTER_LEN + 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             filt_q;
   logic             filt_d;
   logic [RUN_W-1:0] run_q;
   logic [RUN_W-1:0] run_d;

   // Everything resets to the idle-high level so release never fakes an edge.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         filt_q  <= 1'b1;
         run_q   <= '0;
      end else begin
         sync1_q <= tach_i;
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         run_q   <= run_d;
      end
   end

   always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (sync2_q != filt_q) begin
         if (run_q == RUN_W'(FILTER_LEN - 1)) begin
            filt_d = sync2_q;
         end else begin
            run_d = run_q + 1'b1;
         end
      end
   end

   assign fall_o = filt_q & ~filt_d;

endmodule

`default_nettype wire

// File: rtl/fan_tach_meter.sv
// Fan tachometer: counts filtered falling edges per gate window and publishes a
// saturated speed with stall/overflow flags and a one-cycle valid strobe.
`default_nettype none

module fan_tach_meter
   import fan_tach_meter_pkg::*;
#(
   parameter logic [23:0] GATE_CLK_DIV = GATE_CLK_DIV_DEF,
   parameter int unsigned FILTER_LEN   = FILTER_LEN_DEF,
   parameter int unsigned ADC_BITWIDTH = ADC_BITWIDTH_DEF
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    en_i,
   input  logic                    tach_i,
   output logic [ADC_BITWIDTH-1:0] speed_o,
   output logic                    valid_o,
   output logic                    stall_o,
   output logic                    overflow_o
);

   localparam logic [ADC_BITWIDTH:0] EDGE_MAX = {(ADC_BITWIDTH + 1){1'b1}};

   logic                    fall_w;
   logic [ADC_BITWIDTH:0]   total_w;

   logic [23:0]             gate_q,     gate_d;
   logic [ADC_BITWIDTH:0]   edge_q,     edge_d;
   logic [ADC_BITWIDTH-1:0] speed_q,    speed_d;
   logic                    valid_q,    valid_d;
   logic                    stall_q,    stall_d;
   logic                    overflow_q, overflow_d;

   tach_glitch_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_filter (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .tach_i (tach_i),
      .fall_o (fall_w)
   );

   // A fall in the terminal cycle is folded into the closing window's total.
   assign total_w = (fall_w && (edge_q != EDGE_MAX)) ? edge_q + 1'b1 : edge_q;

   always_comb begin
      gate_d     = gate_q;
      edge_d     = edge_q;
      speed_d    = speed_q;
      valid_d    = 1'b0;
      stall_d    = stall_q;
      overflow_d = overflow_q;
      if (!en_i) begin
         gate_d = '0;
         edge_d = '0;
      end else if (gate_q == GATE_CLK_DIV) begin
         gate_d     = '0;
         edge_d     = '0;
         valid_d    = 1'b1;
         speed_d    = total_w[ADC_BITWIDTH] ? '1 : total_w[ADC_BITWIDTH-1:0];
         overflow_d = total_w[ADC_BITWIDTH];
         stall_d    = (total_w == '0);
      end else begin
         gate_d = gate_q + 1'b1;
         edge_d = total_w;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         gate_q     <= '0;
         edge_q     <= '0;
         speed_q    <= '0;
         valid_q    <= 1'b0;
         stall_q    <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         gate_q     <= gate_d;
         edge_q     <= edge_d;
         speed_q    <= speed_d;
         valid_q    <= valid_d;
         stall_q    <= stall_d;
         overflow_q <= overflow_d;
      end
   end

   assign speed_o    = speed_q;
   assign valid_o    = valid_q;
   assign stall_o    = stall_q;
   assign overflow_o = overflow_q;

endmodule

`default_nettype wire
